// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter for three add requesters sharing one
// WIDTH-bit adder, with a one-entry registered result buffer.
`default_nettype none

module adder_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       req_i,
  input  logic [WIDTH-1:0] opa0_i,
  input  logic [WIDTH-1:0] opa1_i,
  input  logic [WIDTH-1:0] opa2_i,
  input  logic [WIDTH-1:0] opb0_i,
  input  logic [WIDTH-1:0] opb1_i,
  input  logic [WIDTH-1:0] opb2_i,
  output logic [2:0]       grant_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic [1:0]       result_id_o,
  output logic             result_valid_o,
  input  logic             result_ready_i
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic [1:0]       id_q, id_d;

  logic             can_accept;
  logic             any_grant;
  logic [1:0]       sel;
  logic [2:0]       grant;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH:0]   sum;

  // Search order begins one past the last granted requester.
  always_comb begin
    sel        = 2'd0;
    any_grant  = 1'b0;
    can_accept = (state_q == S_EMPTY) || result_ready_i;
    if (!rst_i && can_accept && (req_i != 3'b000)) begin
      any_grant = 1'b1;
      case (last_q)
        2'd0: begin
          if      (req_i[1]) sel = 2'd1;
          else if (req_i[2]) sel = 2'd2;
          else               sel = 2'd0;
        end
        2'd1: begin
          if      (req_i[2]) sel = 2'd2;
          else if (req_i[0]) sel = 2'd0;
          else               sel = 2'd1;
        end
        default: begin
          if      (req_i[0]) sel = 2'd0;
          else if (req_i[1]) sel = 2'd1;
          else               sel = 2'd2;
        end
      endcase
    end
    grant = any_grant ? (3'b001 << sel) : 3'b000;
  end

  always_comb begin
    case (sel)
      2'd1:    begin op_a = opa1_i; op_b = opb1_i; end
      2'd2:    begin op_a = opa2_i; op_b = opb2_i; end
      default: begin op_a = opa0_i; op_b = opb0_i; end
    endcase
    sum = {1'b0, op_a} + {1'b0, op_b};
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    result_d = result_q;
    carry_d  = carry_q;
    id_d     = id_q;
    if (any_grant) begin
      state_d  = S_FULL;
      last_d   = sel;
      result_d = sum[WIDTH-1:0];
      carry_d  = sum[WIDTH];
      id_d     = sel;
    end else if ((state_q == S_FULL) && result_ready_i) begin
      state_d = S_EMPTY;
    end
  end

  // Last resets to 2 so requester 0 is searched first.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_EMPTY;
      last_q   <= 2'd2;
      result_q <= '0;
      carry_q  <= 1'b0;
      id_q     <= 2'd0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      id_q     <= id_d;
    end
  end

  assign grant_o        = grant;
  assign result_o       = result_q;
  assign carry_o        = carry_q;
  assign result_id_o    = id_q;
  assign result_valid_o = (state_q == S_FULL);

endmodule

`default_nettype wire

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: scoreboard bench for adder_arbiter with a round-robin
// reference model and directed plus random scenarios.
`default_nettype none

module tb_adder_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_r;
  logic        rdy_r;
  logic [31:0] a [3];
  logic [31:0] b [3];
  logic [2:0]  grant;
  logic [31:0] result;
  logic        carry;
  logic [1:0]  rid;
  logic        rvalid;

  adder_arbiter #(.WIDTH(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req_r),
    .opa0_i         (a[0]),
    .opa1_i         (a[1]),
    .opa2_i         (a[2]),
    .opb0_i         (b[0]),
    .opb1_i         (b[1]),
    .opb2_i         (b[2]),
    .grant_o        (grant),
    .result_o       (result),
    .carry_o        (carry),
    .result_id_o    (rid),
    .result_valid_o (rvalid),
    .result_ready_i (rdy_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          m_last;
  logic        m_valid;
  logic [34:0] sb[$];
  logic [2:0]  last_grant;

  // One cycle: drive, check at negedge against the model, advance the model.
  task automatic step(input logic [2:0] req, input logic rdy);
    logic [2:0]  eg;
    int          idx;
    logic [32:0] s;
    req_r = req;
    rdy_r = rdy;
    @(negedge clk);
    eg  = 3'b000;
    idx = -1;
    if (req != 3'b000 && (!m_valid || rdy)) begin
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = (m_last + k) % 3;
        if (idx < 0 && req[c]) idx = c;
      end
    end
    if (idx >= 0) eg[idx] = 1'b1;
    last_grant = grant;
    n_checks++;
    if (grant !== eg) $display("FAIL grant: got %b expected %b", grant, eg);
    else n_pass++;
    n_checks++;
    if (rvalid !== m_valid) $display("FAIL valid: got %b expected %b", rvalid, m_valid);
    else n_pass++;
    if (m_valid) begin
      n_checks++;
      if (sb.size() == 0) $display("FAIL scoreboard: empty while valid expected");
      else if ({rid, carry, result} !== sb[0])
        $display("FAIL result: got id=%0d c=%b r=%h expected id=%0d c=%b r=%h",
                 rid, carry, result, sb[0][34:33], sb[0][32], sb[0][31:0]);
      else n_pass++;
    end
    if (m_valid && rdy) begin
      if (sb.size() != 0) void'(sb.pop_front());
      m_valid = 1'b0;
    end
    if (idx >= 0) begin
      s = {1'b0, a[idx]} + {1'b0, b[idx]};
      sb.push_back({2'(idx), s});
      m_valid = 1'b1;
      m_last  = idx;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_last  = 2;
    m_valid = 1'b0;
    sb.delete();
  endtask

  task automatic do_reset();
    req_r = 3'b000;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    req_r = 3'b111;
    rdy_r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a[i] = 32'h10 * (i + 1);
      b[i] = 32'h1;
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (grant !== 3'b000) $display("FAIL reset_grant: got %b expected 000", grant);
    else n_pass++;
    n_checks++;
    if ({rvalid, carry, rid, result} !== 36'd0)
      $display("FAIL reset_outputs: got v=%b c=%b id=%0d r=%h expected all 0", rvalid, carry, rid, result);
    else n_pass++;
    rst = 1'b0;
    req_r = 3'b000;
    model_reset();
  endtask

  task automatic test_basic();
    a[0] = 32'h0040_0000;
    b[0] = 32'd4;
    step(3'b001, 1'b1);
    n_checks++;
    if ({rvalid, carry, rid, result} !== {1'b1, 1'b0, 2'd0, 32'h0040_0004})
      $display("FAIL basic_add: got v=%b c=%b id=%0d r=%h expected v=1 c=0 id=0 r=00400004",
               rvalid, carry, rid, result);
    else n_pass++;
    step(3'b000, 1'b1);
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [6];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a[i] = 32'h100 * (i + 1);
      b[i] = 32'd7 + i;
    end
    for (int i = 0; i < 6; i++) begin
      step(3'b111, 1'b1);
      n_checks++;
      if (last_grant !== exp_g[i])
        $display("FAIL rr_seq[%0d]: got %b expected %b", i, last_grant, exp_g[i]);
      else n_pass++;
    end
    step(3'b000, 1'b1);
  endtask

  task automatic test_wrap();
    a[1] = 32'hFFFF_FFFF;
    b[1] = 32'd1;
    step(3'b010, 1'b1);
    n_checks++;
    if ({carry, rid, result} !== {1'b1, 2'd1, 32'h0})
      $display("FAIL wrap: got c=%b id=%0d r=%h expected c=1 id=1 r=00000000", carry, rid, result);
    else n_pass++;
    step(3'b000, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    a[0] = 32'h1234; b[0] = 32'h1;
    a[2] = 32'h5000; b[2] = 32'h5;
    step(3'b001, 1'b1);
    held = result;
    for (int i = 0; i < 3; i++) begin
      step(3'b101, 1'b0);
      n_checks++;
      if (result !== held || rid !== 2'd0)
        $display("FAIL hold[%0d]: got r=%h id=%0d expected r=%h id=0", i, result, rid, held);
      else n_pass++;
    end
    step(3'b101, 1'b1);
    n_checks++;
    if (last_grant === 3'b000) $display("FAIL release_grant: got %b expected nonzero", last_grant);
    else n_pass++;
    step(3'b000, 1'b1);
  endtask

  task automatic test_async_reset();
    a[0] = 32'hAAAA_0000; b[0] = 32'h0000_5555;
    step(3'b001, 1'b0);
    req_r = 3'b000;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({rvalid, carry, rid, result} !== 36'd0)
      $display("FAIL async_reset: got v=%b c=%b id=%0d r=%h expected all 0", rvalid, carry, rid, result);
    else n_pass++;
    #1;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    a[1] = 32'h77; b[1] = 32'h11;
    a[2] = 32'h99; b[2] = 32'h22;
    step(3'b110, 1'b1);
    n_checks++;
    if (last_grant !== 3'b010) $display("FAIL post_reset_grant: got %b expected 010", last_grant);
    else n_pass++;
    step(3'b000, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < 3; j++) begin
        a[j] = $urandom;
        b[j] = (i % 4 == 0) ? 32'hFFFF_FFFF : $urandom;
      end
      step(3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
    end
    step(3'b000, 1'b1);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Reset  input  1  reset is asynchronous and active-high.
REQ-004 Req  input  3  per-requester add request; bit 0 PC increment, bit 1 branch target, bit 2 load/store address.
REQ-005 OpA0, OpA1, OpA2  input  WIDTH each  first operand of requester 0/1/2.
REQ-006 OpB0, OpB1, OpB2  input  WIDTH each  second operand of requester 0/1/2.
REQ-007 Grant  output  3  one-hot combinational grant; operands of granted requester captured on the next rising edge.
REQ-008 Result  output  WIDTH  registered sum OpA+OpB of the last accepted request, modulo 2^WIDTH.
REQ-009 Carry  output  1  registered carry-out (bit WIDTH) of that sum.
REQ-010 ResultId  output  2  registered index (0-2) of the requester owning Result.
REQ-011 ResultValid  output  1  Result/Carry/ResultId hold a result not yet consumed.
REQ-012 ResultReady  input  1  consumer accepts the result in any cycle where ResultValid and ResultReady are both high.

Function
REQ-013 Block contains exactly one WIDTH-bit adder shared by all requesters; no per-requester adders.
REQ-014 Output register is a one-entry buffer with states EMPTY (ResultValid=0) and FULL (ResultValid=1).
REQ-015 Grant is nonzero only when Req is nonzero and the buffer can accept: EMPTY, or FULL with ResultReady high in the same cycle.
REQ-016 At most one Grant bit high per cycle; Grant bit i high only if Req bit i high.
REQ-017 Arbitration is round-robin: search order starts at (Last+1) mod 3, where Last is the index of the most recent granted requester.
REQ-018 Last updates only on a cycle with nonzero Grant; a cycle with no grant leaves Last unchanged.
REQ-019 On a grant edge: Result <= OpA_i+OpB_i (low WIDTH bits), Carry <= bit WIDTH, ResultId <= i, ResultValid <= 1.
REQ-020 Latency: request granted in cycle N produces ResultValid=1 with its result in cycle N+1.
REQ-021 Consume without new grant (ResultValid & ResultReady, Grant=0): ResultValid <= 0; Result, Carry, ResultId hold their values.
REQ-022 Simultaneous consume and grant: new result loads, ResultValid stays 1; sustained throughput one add per cycle.
REQ-023 FULL with ResultReady low: Grant=0; Result, Carry, ResultId, ResultValid held stable until consumed.
REQ-024 ResultReady while EMPTY is ignored.
REQ-025 Requester holds Req and operands stable until it sees its Grant bit; requester sees Grant in cycle N and drops Req or presents a new request from cycle N+1.
REQ-026 Wrap-around: sum 2^WIDTH or larger truncates to low WIDTH bits and sets Carry=1; no saturation, no exception.
REQ-027 Operand and Req changes in a cycle with no grant have no effect on state.

Reset
REQ-028 Reset high forces, without waiting for Clk: ResultValid=0, Result=0, Carry=0, ResultId=0, Last=2 (requester 0 has first priority).
REQ-029 Grant is 0 while Reset is high regardless of Req.
REQ-030 Reset asserted mid-operation discards any buffered result; no partial or stale result appears after release.
REQ-031 First grant may occur in the first cycle Reset is low.

Verification
REQ-032 After reset, Req=001, OpA0=0x00400000, OpB0=4, ResultReady=1 -> Grant=001 that cycle; next cycle Result=0x00400004, Carry=0, ResultId=0, ResultValid=1.
REQ-033 Req=111 held 6 cycles, ResultReady=1 -> Grant sequence 001,010,100,001,010,100; ResultValid high continuously from cycle 2; ResultId 0,1,2,0,1,2.
REQ-034 OpA1=0xFFFFFFFF, OpB1=1, Req=010 -> Result=0x00000000, Carry=1, ResultId=1.
REQ-035 Result FULL, ResultReady=0 for 3 cycles with Req=101 -> Grant=000 and Result/ResultId unchanged all 3 cycles; ResultReady=1 on cycle 4 -> Grant nonzero same cycle, new result next cycle.
REQ-036 Reset pulsed asynchronously between edges while ResultValid=1 -> ResultValid, Result, Carry, ResultId go to 0 immediately; with Req=110 after release, first Grant=010.
